// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: registers the ALU result, evaluates the ARM condition
// field against the committed NZCV register and issues one register write,
// memory request or branch per beat over a valid/ready handshake.
// Optional build macro: WB_PERF_CNT_EN enables the retired/skipped counters.
module alu_writeback_stage #(
  parameter int REG_AW = 4,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     alu_out,
  input  logic [3:0]        alu_flag,
  input  logic [1:0]        op,
  input  logic [3:0]        cmd,
  input  logic [3:0]        cond,
  input  logic              s_bit,
  input  logic [REG_AW-1:0] rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DW-1:0]     wb_data,
  output logic              mem_req,
  output logic [DW-1:0]     mem_addr,
  output logic              br_taken,
  output logic [DW-1:0]     br_target,
  output logic [3:0]        nzcv,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       skipped_cnt
);

  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [1:0] OP_DP   = 2'd0;
  localparam logic [1:0] OP_MEM  = 2'd1;
  localparam logic [1:0] OP_BR   = 2'd2;
  localparam logic [1:0] OP_INV  = 2'd3;

  logic accept;
  logic cond_pass;
  logic issue;
  logic is_cmp;
  logic flag_n, flag_z, flag_c, flag_v;

  assign {flag_n, flag_z, flag_c, flag_v} = nzcv;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_cmp   = (cmd == CMD_CMP);
  assign issue    = cond_pass && (op != OP_INV);

  // ARM condition evaluation against the committed (pre-update) flags
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Output beat register; sideband data holds while stalled or idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      br_taken  <= 1'b0;
      br_target <= '0;
    end else if (accept) begin
      // Skipped beats still consume the slot, so the register empties
      out_valid <= issue;
      wb_we     <= 1'b0;
      mem_req   <= 1'b0;
      br_taken  <= 1'b0;
      if (issue) begin
        case (op)
          OP_DP: begin
            wb_we   <= !is_cmp;
            wb_rd   <= rd;
            wb_data <= alu_out;
          end
          OP_MEM: begin
            mem_req  <= 1'b1;
            mem_addr <= alu_out;
            wb_rd    <= rd;
          end
          OP_BR: begin
            br_taken  <= 1'b1;
            br_target <= alu_out;
          end
          default: ;
        endcase
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
      wb_we     <= 1'b0;
      mem_req   <= 1'b0;
      br_taken  <= 1'b0;
    end
  end

  // Architectural flag register, written by flag-setting data-processing ops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nzcv <= 4'b0000;
    end else if (accept && issue && (op == OP_DP) && (s_bit || is_cmp)) begin
      nzcv <= alu_flag;
    end
  end

`ifdef WB_PERF_CNT_EN
  // Performance counters for issued and skipped beats, wrapping at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt <= '0;
      skipped_cnt <= '0;
    end else if (accept) begin
      if (issue) retired_cnt <= retired_cnt + 32'd1;
      else       skipped_cnt <= skipped_cnt + 32'd1;
    end
  end
`else
  assign retired_cnt = '0;
  assign skipped_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Randomized self-checking bench for alu_writeback_stage with a transaction-level
// reference model of the issued beat, flag register and counters.
module tb_alu_writeback_stage;
  localparam int REG_AW = 4;
  localparam int DW     = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready;
  logic [DW-1:0]     alu_out;
  logic [3:0]        alu_flag;
  logic [1:0]        op;
  logic [3:0]        cmd, cond;
  logic              s_bit;
  logic [REG_AW-1:0] rd;
  logic              out_valid, out_ready;
  logic              wb_we, mem_req, br_taken;
  logic [REG_AW-1:0] wb_rd;
  logic [DW-1:0]     wb_data, mem_addr, br_target;
  logic [3:0]        nzcv;
  logic [31:0]       retired_cnt, skipped_cnt;

  always #5 clk = ~clk;

  alu_writeback_stage #(.REG_AW(REG_AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_flag(alu_flag), .op(op), .cmd(cmd), .cond(cond),
    .s_bit(s_bit), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .mem_req(mem_req),
    .mem_addr(mem_addr), .br_taken(br_taken), .br_target(br_target),
    .nzcv(nzcv), .retired_cnt(retired_cnt), .skipped_cnt(skipped_cnt)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Reference model state: the beat currently presented downstream
  logic        m_valid, m_we, m_mem, m_br;
  logic [3:0]  m_rd;
  logic [31:0] m_data, m_addr, m_tgt;
  logic [3:0]  m_nzcv;
  logic [31:0] m_ret, m_skip;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      0: return z;            1: return !z;
      2: return cy;           3: return !cy;
      4: return n;            5: return !n;
      6: return v;            7: return !v;
      8: return cy && !z;     9: return !cy || z;
      10: return n == v;      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    m_valid = 0; m_we = 0; m_mem = 0; m_br = 0;
    m_rd = '0; m_data = '0; m_addr = '0; m_tgt = '0;
    m_nzcv = '0; m_ret = '0; m_skip = '0;
  endtask

  task automatic check_outputs();
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("wb_we",     {31'd0, wb_we},     {31'd0, m_we});
    check("mem_req",   {31'd0, mem_req},   {31'd0, m_mem});
    check("br_taken",  {31'd0, br_taken},  {31'd0, m_br});
    if (m_we)  begin check("wb_rd", {28'd0, wb_rd}, {28'd0, m_rd}); check("wb_data", wb_data, m_data); end
    if (m_mem) begin check("mem_rd", {28'd0, wb_rd}, {28'd0, m_rd}); check("mem_addr", mem_addr, m_addr); end
    if (m_br)  check("br_target", br_target, m_tgt);
    check("nzcv", {28'd0, nzcv}, {28'd0, m_nzcv});
`ifdef WB_PERF_CNT_EN
    check("retired_cnt", retired_cnt, m_ret);
    check("skipped_cnt", skipped_cnt, m_skip);
`else
    check("retired_cnt", retired_cnt, 32'd0);
    check("skipped_cnt", skipped_cnt, 32'd0);
`endif
  endtask

  // One clock cycle: drive at negedge, step the model at the edge, check after it
  task automatic cycle(input logic iv, input logic orr, input logic [1:0] o,
                       input logic [3:0] cm, input logic [3:0] cd, input logic s,
                       input logic [3:0] r, input logic [31:0] a, input logic [3:0] f);
    logic acc, pass;
    @(negedge clk);
    in_valid = iv; out_ready = orr; op = o; cmd = cm; cond = cd;
    s_bit = s; rd = r; alu_out = a; alu_flag = f;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || orr)});
    acc = iv && (!m_valid || orr);
    @(posedge clk);
    if (acc) begin
      pass = cond_ok(cd, m_nzcv) && (o != 2'd3);
      m_we = 0; m_mem = 0; m_br = 0;
      if (pass) begin
        m_valid = 1;
        m_ret++;
        if (o == 2'd0) begin
          m_we = (cm != 4'b1010); m_rd = r; m_data = a;
          if (s || cm == 4'b1010) m_nzcv = f;
        end else if (o == 2'd1) begin
          m_mem = 1; m_addr = a; m_rd = r;
        end else begin
          m_br = 1; m_tgt = a;
        end
      end else begin
        m_valid = 0;
        m_skip++;
      end
    end else if (m_valid && orr) begin
      m_valid = 0; m_we = 0; m_mem = 0; m_br = 0;
    end
    #1;
    check_outputs();
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge
  task automatic async_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    model_clear();
    check_outputs();
    check("wb_data_rst", wb_data, 32'd0);
    check("mem_addr_rst", mem_addr, 32'd0);
    check("br_target_rst", br_target, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; out_ready = 0; op = 0; cmd = 0; cond = 0;
    s_bit = 0; rd = 0; alu_out = 0; alu_flag = 0;
    model_clear();
    #12;
    check_outputs();
    check("wb_data_rst", wb_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Plain write with flag set
    cycle(1, 1, 2'd0, 4'b0100, 4'd14, 1, 4'd3, 32'd5, 4'b0000);
    // CMP setting Z, then dependent BEQ on the next cycle
    cycle(1, 1, 2'd0, 4'b1010, 4'd14, 0, 4'd1, 32'd9, 4'b0100);
    cycle(1, 1, 2'd2, 4'b0000, 4'd0, 0, 4'd0, 32'h40, 4'b0000);
    cycle(0, 1, 2'd0, 4'b0000, 4'd0, 0, 4'd0, 32'd0, 4'b0000);
    // Condition fail with cleared flags
    async_reset();
    cycle(1, 1, 2'd0, 4'b0100, 4'd0, 1, 4'd1, 32'd7, 4'b1111);
    // Never condition and op 3 are skipped
    cycle(1, 1, 2'd0, 4'b0100, 4'd15, 1, 4'd2, 32'd8, 4'b1111);
    cycle(1, 1, 2'd3, 4'b0100, 4'd14, 1, 4'd2, 32'd8, 4'b1111);
    // Stall holding a write, second beat waits, then both drain back to back
    cycle(1, 0, 2'd0, 4'b0100, 4'd14, 0, 4'd6, 32'hDEADBEEF, 4'b0000);
    for (int i = 0; i < 3; i++)
      cycle(1, 0, 2'd0, 4'b0100, 4'd14, 0, 4'd7, 32'h12345678, 4'b0000);
    cycle(1, 1, 2'd0, 4'b0100, 4'd14, 0, 4'd7, 32'h12345678, 4'b0000);
    cycle(0, 1, 2'd0, 4'b0000, 4'd0, 0, 4'd0, 32'd0, 4'b0000);
    // Memory op ignores s_bit for flags
    cycle(1, 1, 2'd1, 4'b0100, 4'd14, 1, 4'd4, 32'h100, 4'b1010);
    // Flags set, beat stalled, then reset mid-stall
    cycle(1, 1, 2'd0, 4'b0100, 4'd14, 1, 4'd5, 32'd1, 4'b1010);
    cycle(1, 0, 2'd0, 4'b0100, 4'd14, 0, 4'd5, 32'd2, 4'b0000);
    async_reset();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] cm;
      cm = ($urandom_range(0, 3) == 0) ? 4'b1010 : 4'($urandom);
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
            2'($urandom), cm, 4'($urandom), 1'($urandom), 4'($urandom),
            32'($urandom), 4'($urandom));
      if (i == 200) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_writeback_stage.md
# alu_writeback_stage

Pipeline stage directly downstream of the ALU. It registers the ALU result and the `{N,Z,C,V}` flag vector and evaluates the ARM condition field against the committed flag register. It then issues a register-file write, memory request or branch to the next stage over a valid/ready handshake. It owns the architectural NZCV register, which upstream condition logic reads.

## Interface
Parameters:
- `REG_AW`, 4: register index width (16 registers).
- `DW`, 32: datapath width; matches the ALU result.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream beat present.
- `in_ready` out 1: stage can accept; equals `!out_valid || out_ready`.
- `alu_out` in DW: ALU result.
- `alu_flag` in 4: ALU flags; bit3=N, bit2=Z, bit1=C, bit0=V.
- `op` in 2: instruction class; 0=data-processing, 1=memory, 2=branch, 3=invalid.
- `cmd` in 4: data-processing opcode; `4'b1010`=CMP.
- `cond` in 4: ARM condition code.
- `s_bit` in 1: set-flags request.
- `rd` in REG_AW: destination register.
- `out_valid` out 1: registered beat present.
- `out_ready` in 1: downstream accepts.
- `wb_we` out 1: register write enable.
- `wb_rd` out REG_AW: register write index.
- `wb_data` out DW: register write data.
- `mem_req` out 1: memory request.
- `mem_addr` out DW: memory address.
- `br_taken` out 1: branch redirect.
- `br_target` out DW: branch target.
- `nzcv` out 4: committed flags.
- `retired_cnt` out 32: perf counter; see Configuration.
- `skipped_cnt` out 32: perf counter; see Configuration.

## Operation
- Accept occurs when `in_valid && in_ready`; all decisions are made at the accept edge.
- Condition pass is evaluated against `nzcv` before update, using the standard ARM set:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z.
  - GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL (1110) = 1; 1111 = never (reserved).
- Condition pass, op 0:
  - `wb_we=1`, `wb_rd=rd`, `wb_data=alu_out`.
  - Exception: CMP sets `wb_we=0`.
  - `nzcv <= alu_flag` if `s_bit` or cmd==CMP.
- Condition pass, op 1: `mem_req=1`, `mem_addr=alu_out`, `wb_rd=rd`. No write and no flag update.
- Condition pass, op 2: `br_taken=1`, `br_target=alu_out`. No flag update.
- op 3, or condition fail: the beat is consumed with `in_ready` honoured. No output beat and no flag update; the skip is counted.
- Output sideband (`wb_*`, `mem_*`, `br_*`) holds stable while `out_valid && !out_ready`.
- When `out_valid=0`, `wb_we`, `mem_req` and `br_taken` are 0.
- Exactly one of `wb_we`, `mem_req` or `br_taken` is high per valid beat, except CMP, which issues a beat with all three low. This keeps ordering visible downstream.

## Timing
- Latency is 1 cycle: a beat accepted at edge k gives `out_valid=1` after edge k.
- `nzcv` updates at the accept edge. The instruction accepted at edge k+1 sees the flags from edge k, so back-to-back dependent conditions work without stall.
- Throughput is 1 beat/cycle while `out_ready=1`.
- `in_ready` is combinational from `out_valid` and `out_ready`.
- Out-going beat plus new accept in the same cycle: the output register reloads with no bubble.
- A condition-fail accept while `out_valid && out_ready`: `out_valid` drops to 0 next cycle.
- Reset, asynchronous and any time, including mid-stall: `out_valid=0`, `wb_we=0`, `mem_req=0`, `br_taken=0`, all data outputs 0, `nzcv=4'b0000`, counters 0. Any in-flight beat is lost.

## Configuration
- `WB_PERF_CNT_EN` defined:
  - `retired_cnt` increments on each condition-pass accept with op≠3.
  - `skipped_cnt` increments on each condition-fail or op==3 accept.
  - Both counters are 32-bit and wrap 0xFFFFFFFF→0.
- Not defined: both ports are constant 0 and no counter flops are built.

## Test plan
- Reset, then accept op0/cmd=0100/AL/s=1/rd=3/alu_out=5/alu_flag=0000 with out_ready=1 → next cycle out_valid=1, wb_we=1, wb_rd=3, wb_data=5, nzcv=0000.
- CMP with alu_flag=0100 (Z), then next cycle a BEQ (op2, cond=0000, alu_out=0x40) → CMP beat has all enables low; the branch beat shows br_taken=1, br_target=0x40.
- nzcv=0000, accept op0 with cond=EQ → no output beat; nzcv unchanged; skipped_cnt=1 with WB_PERF_CNT_EN.
- out_ready=0 for 3 cycles holding a write of 0xDEADBEEF → in_ready=0, outputs stable, a second in_valid beat waits; on out_ready=1 both beats emerge on consecutive cycles.
- op1/cond=AL/alu_out=0x100 → mem_req=1, mem_addr=0x100, wb_we=0, nzcv unchanged even with s_bit=1.
- Assert reset while a beat is stalled → out_valid=0 and nzcv=0000 immediately, without waiting for a clock edge.
